// File: rtl/tx_frontend_pkg.sv
// Shared constants and helpers for the transmit frontend.
// Register offsets, DAC mux codes, datapath widths and the 24-bit clamp.
package tx_frontend_pkg;

    localparam int IN_W       = 24;
    localparam int OUT_W      = 16;
    localparam int CORR_W     = 18;
    localparam int PROD_W     = 2 * CORR_W;
    localparam int PROD_SHIFT = 11;
    localparam int SUM_W      = 26;

    localparam logic [7:0] OFS_DC_I     = 8'd0;
    localparam logic [7:0] OFS_DC_Q     = 8'd1;
    localparam logic [7:0] OFS_MAG      = 8'd2;
    localparam logic [7:0] OFS_PHASE    = 8'd3;
    localparam logic [7:0] OFS_MUX      = 8'd4;
    localparam logic [7:0] OFS_CLIP_CLR = 8'd5;

    // Codes as seen by dac_a; dac_b swaps I and Q before decoding.
    localparam logic [1:0] SEL_I    = 2'd0;
    localparam logic [1:0] SEL_Q    = 2'd1;
    localparam logic [1:0] SEL_ZERO = 2'd2;

    localparam logic signed [SUM_W-1:0] IN_MAX = 26'sh07F_FFFF;
    localparam logic signed [SUM_W-1:0] IN_MIN = -26'sh080_0000;

    function automatic logic ovf_in(input logic signed [SUM_W-1:0] x);
        return (x > IN_MAX) || (x < IN_MIN);
    endfunction

    function automatic logic signed [IN_W-1:0] sat_in(
        input logic signed [SUM_W-1:0] x
    );
        if (x > IN_MAX) begin
            return {1'b0, {(IN_W-1){1'b1}}};
        end else if (x < IN_MIN) begin
            return {1'b1, {(IN_W-1){1'b0}}};
        end
        return x[IN_W-1:0];
    endfunction

endpackage

// File: rtl/setting_reg.sv
// Settings-bus register: loads din on a strobe at its own address.
// Clears to AT_RESET on synchronous reset.
module setting_reg #(
    parameter logic [7:0]       MY_ADDR  = 8'd0,
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] AT_RESET = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe,
    input  logic [7:0]       addr,
    input  logic [31:0]      din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] val_d;
    logic             unused_din;

    assign unused_din = ^din;

    always_comb begin
        val_d = val_q;
        if (strobe && (addr == MY_ADDR)) begin
            val_d = din[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= AT_RESET;
        end else begin
            val_q <= val_d;
        end
    end

    assign dout = val_q;

endmodule

// File: rtl/tx_round_sat.sv
// Registered offset add, round-half-up and saturate to OUT_W bits.
// clip flags the value being loaded this cycle as clamped.
module tx_round_sat
    import tx_frontend_pkg::*;
#(
    parameter int XW = IN_W,
    parameter int YW = OUT_W,
    parameter int SW = SUM_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [XW-1:0] x,
    input  logic signed [XW-1:0] ofs,
    output logic signed [YW-1:0] y,
    output logic                 clip
);

    localparam int SH = XW - YW;
    localparam logic signed [SW-1:0] RND  = SW'(1 << (SH - 1));
    localparam logic signed [SW-1:0] MAXV = SW'((1 << (YW - 1)) - 1);
    localparam logic signed [SW-1:0] MINV = SW'(-(1 << (YW - 1)));

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] sh;
    logic                 hi;
    logic                 lo;
    logic signed [YW-1:0] y_d;
    logic signed [YW-1:0] y_q;

    always_comb begin
        sum = SW'(x) + SW'(ofs) + RND;
        sh  = sum >>> SH;
        hi  = sh > MAXV;
        lo  = sh < MINV;
        y_d = sh[YW-1:0];
        if (hi) begin
            y_d = {1'b0, {(YW-1){1'b1}}};
        end else if (lo) begin
            y_d = {1'b1, {(YW-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y    = y_q;
    assign clip = hi | lo;

endmodule

// File: rtl/tx_frontend.sv
// TX frontend: run gate, IQ correction, DC offset, round/saturate,
// DAC channel mux and a saturating clip counter; 4-cycle latency.
module tx_frontend
    import tx_frontend_pkg::*;
#(
    parameter logic [7:0] BASE      = 8'd0,
    parameter bit         IQCOMP_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    set_stb,
    input  logic [7:0]              set_addr,
    input  logic [31:0]             set_data,
    input  logic signed [IN_W-1:0]  tx_i,
    input  logic signed [IN_W-1:0]  tx_q,
    input  logic                    run,
    output logic signed [OUT_W-1:0] dac_a,
    output logic signed [OUT_W-1:0] dac_b,
    output logic [31:0]             debug
);

    localparam logic [7:0] A_DC_I  = BASE + OFS_DC_I;
    localparam logic [7:0] A_DC_Q  = BASE + OFS_DC_Q;
    localparam logic [7:0] A_MAG   = BASE + OFS_MAG;
    localparam logic [7:0] A_PHASE = BASE + OFS_PHASE;
    localparam logic [7:0] A_MUX   = BASE + OFS_MUX;
    localparam logic [7:0] A_CLR   = BASE + OFS_CLIP_CLR;

    logic signed [IN_W-1:0]   dc_i;
    logic signed [IN_W-1:0]   dc_q;
    logic signed [CORR_W-1:0] mag_corr;
    logic signed [CORR_W-1:0] phase_corr;
    logic [3:0]               mux;

    setting_reg #(.MY_ADDR(A_DC_I), .WIDTH(IN_W)) u_dc_i (
        .clk(clk), .rst(rst), .strobe(set_stb), .addr(set_addr),
        .din(set_data), .dout(dc_i)
    );
    setting_reg #(.MY_ADDR(A_DC_Q), .WIDTH(IN_W)) u_dc_q (
        .clk(clk), .rst(rst), .strobe(set_stb), .addr(set_addr),
        .din(set_data), .dout(dc_q)
    );
    setting_reg #(.MY_ADDR(A_MAG), .WIDTH(CORR_W)) u_mag (
        .clk(clk), .rst(rst), .strobe(set_stb), .addr(set_addr),
        .din(set_data), .dout(mag_corr)
    );
    setting_reg #(.MY_ADDR(A_PHASE), .WIDTH(CORR_W)) u_phase (
        .clk(clk), .rst(rst), .strobe(set_stb), .addr(set_addr),
        .din(set_data), .dout(phase_corr)
    );
    setting_reg #(.MY_ADDR(A_MUX), .WIDTH(4)) u_mux (
        .clk(clk), .rst(rst), .strobe(set_stb), .addr(set_addr),
        .din(set_data), .dout(mux)
    );

    logic signed [IN_W-1:0]   ri_q, ri_d, rq_q, rq_d;
    logic signed [IN_W-1:0]   ri2_q, rq2_q;
    logic signed [PROD_W-1:0] pm_q, pm_d, pp_q, pp_d;
    logic signed [IN_W-1:0]   ci_q, ci_d, cq_q, cq_d;
    logic signed [CORR_W-1:0] ri_hi;
    logic signed [SUM_W-1:0]  s3_sum_i, s3_sum_q;
    logic                     s3_clip;
    logic [3:0]               sel_q;
    logic [15:0]              clip_cnt_q, clip_cnt_d;
    logic                     clip_clr, clip_evt;
    logic signed [OUT_W-1:0]  oi, oq;
    logic                     s4_clip_i, s4_clip_q;

    always_comb begin
        ri_d  = run ? tx_i : '0;
        rq_d  = run ? tx_q : '0;
        ri_hi = ri_q[IN_W-1:IN_W-CORR_W];
        pm_d  = '0;
        pp_d  = '0;
        if (IQCOMP_EN) begin
            pm_d = PROD_W'(ri_hi) * PROD_W'(mag_corr);
            pp_d = PROD_W'(ri_hi) * PROD_W'(phase_corr);
        end
        s3_sum_i = SUM_W'(ri2_q) + SUM_W'(pm_q >>> PROD_SHIFT);
        s3_sum_q = SUM_W'(rq2_q) + SUM_W'(pp_q >>> PROD_SHIFT);
        ci_d     = sat_in(s3_sum_i);
        cq_d     = sat_in(s3_sum_q);
        s3_clip  = ovf_in(s3_sum_i) | ovf_in(s3_sum_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ri_q  <= '0;
            rq_q  <= '0;
            ri2_q <= '0;
            rq2_q <= '0;
            pm_q  <= '0;
            pp_q  <= '0;
            ci_q  <= '0;
            cq_q  <= '0;
            sel_q <= '0;
        end else begin
            ri_q  <= ri_d;
            rq_q  <= rq_d;
            ri2_q <= ri_q;
            rq2_q <= rq_q;
            pm_q  <= pm_d;
            pp_q  <= pp_d;
            ci_q  <= ci_d;
            cq_q  <= cq_d;
            sel_q <= mux;
        end
    end

    tx_round_sat u_rs_i (
        .clk(clk), .rst(rst), .x(ci_q), .ofs(dc_i),
        .y(oi), .clip(s4_clip_i)
    );
    tx_round_sat u_rs_q (
        .clk(clk), .rst(rst), .x(cq_q), .ofs(dc_q),
        .y(oq), .clip(s4_clip_q)
    );

    // Select captured with the S4 data, so the mux acts as an S4 register.
    function automatic logic signed [OUT_W-1:0] pick(
        input logic [1:0]              s,
        input logic signed [OUT_W-1:0] i,
        input logic signed [OUT_W-1:0] q
    );
        case (s)
            SEL_I:   return i;
            SEL_Q:   return q;
            default: return '0;
        endcase
    endfunction

    assign dac_a = pick(sel_q[1:0], oi, oq);
    assign dac_b = pick(sel_q[3:2] ^ 2'b01, oi, oq);

    always_comb begin
        clip_clr   = set_stb && (set_addr == A_CLR);
        clip_evt   = s3_clip | s4_clip_i | s4_clip_q;
        clip_cnt_d = clip_cnt_q;
        if (clip_clr) begin
            clip_cnt_d = '0;
        end else if (clip_evt && (clip_cnt_q != 16'hFFFF)) begin
            clip_cnt_d = clip_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clip_cnt_q <= '0;
        end else begin
            clip_cnt_q <= clip_cnt_d;
        end
    end

    assign debug = {clip_cnt_q, run, 7'b0, dac_a[15:8]};

endmodule

// File: tb/tb_tx_frontend.sv
// Random and directed bench for tx_frontend, with and without IQ correction.
// An arithmetic reference model tracks both variants cycle by cycle.
module tb_tx_frontend;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic [23:0] tx_i = '0;
    logic [23:0] tx_q = '0;
    logic [15:0] a1, b1, a0, b0;
    logic [31:0] d1, d0;

    int n_tot  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    tx_frontend #(.BASE(8'd0), .IQCOMP_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .set_stb(set_stb), .set_addr(set_addr),
        .set_data(set_data), .tx_i(tx_i), .tx_q(tx_q), .run(run),
        .dac_a(a1), .dac_b(b1), .debug(d1)
    );

    tx_frontend #(.BASE(8'd0), .IQCOMP_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .set_stb(set_stb), .set_addr(set_addr),
        .set_data(set_data), .tx_i(tx_i), .tx_q(tx_q), .run(run),
        .dac_a(a0), .dac_b(b0), .debug(d0)
    );

    typedef struct {
        longint r1i, r1q, r2i, r2q, pm, pp, ci, cq, oi, oq;
        longint dci, dcq, mag, ph;
        int     sel, mux, cnt;
    } mdl_t;

    mdl_t m[2];

    function automatic longint sx(input logic [31:0] v, input int w);
        longint t;
        t = longint'(v) & ((64'sd1 <<< w) - 1);
        if (t >= (64'sd1 <<< (w - 1))) t = t - (64'sd1 <<< w);
        return t;
    endfunction

    function automatic longint clamp(input longint x, input int w);
        longint hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic bit clips(input longint x, input int w);
        return x != clamp(x, w);
    endfunction

    // Next state of the whole frontend after one clock edge.
    function automatic mdl_t step(input mdl_t s, input bit en, input bit r,
                                  input bit rn, input logic [23:0] ti,
                                  input logic [23:0] tq, input bit stb,
                                  input logic [7:0] ad, input logic [31:0] d);
        mdl_t   n;
        longint s3i, s3q, s4i, s4q;
        bit     ev;
        n = s;
        if (r) begin
            n = '{default: 0};
            return n;
        end
        s4i   = (s.ci + s.dci + 128) >>> 8;
        s4q   = (s.cq + s.dcq + 128) >>> 8;
        s3i   = s.r2i + (s.pm >>> 11);
        s3q   = s.r2q + (s.pp >>> 11);
        n.oi  = clamp(s4i, 16);
        n.oq  = clamp(s4q, 16);
        n.ci  = clamp(s3i, 24);
        n.cq  = clamp(s3q, 24);
        n.sel = s.mux;
        n.pm  = en ? (s.r1i >>> 6) * s.mag : 0;
        n.pp  = en ? (s.r1i >>> 6) * s.ph : 0;
        n.r2i = s.r1i;
        n.r2q = s.r1q;
        n.r1i = rn ? sx({8'b0, ti}, 24) : 0;
        n.r1q = rn ? sx({8'b0, tq}, 24) : 0;
        ev = clips(s4i, 16) || clips(s4q, 16) || clips(s3i, 24) || clips(s3q, 24);
        if (stb && ad == 8'd5) n.cnt = 0;
        else if (ev && s.cnt < 65535) n.cnt = s.cnt + 1;
        if (stb) begin
            case (ad)
                8'd0: n.dci = sx(d, 24);
                8'd1: n.dcq = sx(d, 24);
                8'd2: n.mag = sx(d, 18);
                8'd3: n.ph  = sx(d, 18);
                8'd4: n.mux = int'(d[3:0]);
                default: ;
            endcase
        end
        return n;
    endfunction

    function automatic logic [15:0] pick(input int code, input longint x,
                                         input longint y);
        if (code == 0) return 16'(x);
        if (code == 1) return 16'(y);
        return 16'h0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic cycle(input bit r, input bit rn, input logic [23:0] ti,
                         input logic [23:0] tq, input bit stb,
                         input logic [7:0] ad, input logic [31:0] d);
        logic [15:0] ea, eb;
        rst = r; run = rn; tx_i = ti; tx_q = tq;
        set_stb = stb; set_addr = ad; set_data = d;
        @(posedge clk);
        #1;
        m[0] = step(m[0], 1'b0, r, rn, ti, tq, stb, ad, d);
        m[1] = step(m[1], 1'b1, r, rn, ti, tq, stb, ad, d);
        for (int k = 0; k < 2; k++) begin
            ea = pick(m[k].sel & 3, m[k].oi, m[k].oq);
            eb = pick((m[k].sel >> 2) & 3, m[k].oq, m[k].oi);
            chk($sformatf("dac_a[en%0d]", k), {16'b0, k == 1 ? a1 : a0}, {16'b0, ea});
            chk($sformatf("dac_b[en%0d]", k), {16'b0, k == 1 ? b1 : b0}, {16'b0, eb});
            chk($sformatf("debug[en%0d]", k), k == 1 ? d1 : d0,
                {16'(m[k].cnt), rn, 7'b0, ea[15:8]});
        end
    endtask

    logic [23:0] li = '0;
    logic [23:0] lq = '0;

    task automatic hold(input logic [23:0] ti, input logic [23:0] tq, input int n);
        li = ti; lq = tq;
        for (int c = 0; c < n; c++) cycle(1'b0, 1'b1, ti, tq, 1'b0, 8'd0, 32'd0);
    endtask

    task automatic wr(input logic [7:0] ad, input logic [31:0] d);
        cycle(1'b0, 1'b1, li, lq, 1'b1, ad, d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        m[0] = '{default: 0};
        m[1] = '{default: 0};

        cycle(1'b1, 1'b0, 24'h0, 24'h0, 1'b0, 8'd0, 32'd0);
        cycle(1'b1, 1'b0, 24'h0, 24'h0, 1'b0, 8'd0, 32'd0);
        chk("lit_reset_a", {16'b0, a1}, 32'h0);
        chk("lit_reset_dbg", d1, 32'h0);

        hold(24'h123400, 24'hFEDC00, 4);
        chk("lit_pass_a", {16'b0, a1}, 32'h1234);
        chk("lit_pass_b", {16'b0, b1}, 32'hFEDC);
        chk("lit_pass_cnt", {16'b0, d1[31:16]}, 32'h0);

        hold(24'h000080, 24'h0, 4);
        chk("lit_rnd_80", {16'b0, a1}, 32'h0001);
        hold(24'h00007F, 24'h0, 4);
        chk("lit_rnd_7f", {16'b0, a1}, 32'h0000);
        hold(24'hFFFF80, 24'h0, 4);
        chk("lit_rnd_neg", {16'b0, a1}, 32'h0000);

        wr(8'd2, 32'h10000);
        wr(8'd3, 32'h10000);
        hold(24'h200000, 24'h0, 4);
        chk("lit_corr_a", {16'b0, a1}, 32'h3000);
        chk("lit_corr_b", {16'b0, b1}, 32'h1000);
        chk("lit_nocorr_a", {16'b0, a0}, 32'h2000);
        chk("lit_nocorr_b", {16'b0, b0}, 32'h0000);
        wr(8'd2, 32'h0);
        wr(8'd3, 32'h0);

        wr(8'd0, 32'h100);
        hold(24'h0, 24'h0, 4);
        chk("lit_dc", {16'b0, a1}, 32'h0001);

        wr(8'd0, 32'h10000);
        hold(24'h7FFF00, 24'h0, 4);
        chk("lit_sat_a", {16'b0, a1}, 32'h7FFF);
        chk("lit_clip1", {16'b0, d1[31:16]}, 32'h1);
        hold(24'h7FFF00, 24'h0, 2);
        chk("lit_clip3", {16'b0, d1[31:16]}, 32'h3);
        wr(8'd5, 32'hDEAD);
        chk("lit_clip_clr", {16'b0, d1[31:16]}, 32'h0);
        wr(8'd0, 32'h0);

        wr(8'd4, 32'h1);
        hold(24'h111100, 24'h222200, 4);
        chk("lit_mux1_a", {16'b0, a1}, 32'h2222);
        chk("lit_mux1_b", {16'b0, b1}, 32'h2222);
        wr(8'd4, 32'hA);
        hold(24'h111100, 24'h222200, 4);
        chk("lit_muxA_a", {16'b0, a1}, 32'h0);
        chk("lit_muxA_b", {16'b0, b1}, 32'h0);
        wr(8'd4, 32'h0);

        wr(8'd1, 32'h200);
        hold(24'h0, 24'h050000, 4);
        cycle(1'b0, 1'b0, 24'h0, 24'h050000, 1'b0, 8'd0, 32'd0);
        hold(24'h0, 24'h050000, 3);
        chk("lit_runlow_b", {16'b0, b1}, 32'h0002);
        hold(24'h0, 24'h050000, 1);
        chk("lit_runhigh_b", {16'b0, b1}, 32'h0502);

        hold(24'h123400, 24'h050000, 4);
        cycle(1'b1, 1'b1, 24'h123400, 24'h050000, 1'b0, 8'd0, 32'd0);
        chk("lit_mid_rst_a", {16'b0, a1}, 32'h0);
        chk("lit_mid_rst_b", {16'b0, b1}, 32'h0);
        hold(24'h123400, 24'h050000, 3);
        chk("lit_post_rst_early", {16'b0, a1}, 32'h0);
        hold(24'h123400, 24'h050000, 1);
        chk("lit_post_rst_a", {16'b0, a1}, 32'h1234);
        chk("lit_post_rst_b", {16'b0, b1}, 32'h0500);

        for (int c = 0; c < 3000; c++) begin
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 15) != 0,
                  24'($urandom), 24'($urandom),
                  $urandom_range(0, 7) == 0,
                  8'($urandom_range(0, 6)),
                  $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
